controle_ula: RTL and testbench
===============================

Name: controle_ula

Overview:
- Sequencing and arbitration controller that shares the single combinational ULA between two requesters: port A (processor datapath) and port B (auxiliary/debug unit).
- Registers the selected operands and opcode onto the ULA inputs and holds them for a fixed settle window (covers the slow divide/multiply paths).
- Captures the 32-bit ULA result and returns it through a req/done handshake.
- Sits between the requesters and the ULA; the ULA itself is unchanged.

Parameters:
- LATENCIA, 2: settle cycles the ULA inputs are held before the result is captured; legal range 1..15.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_a  input  1  request from port A; held high until done_a is seen
- operando1_a  input  16  port A first operand; stable while req_a high
- operando2_a  input  16  port A second operand; stable while req_a high
- opcode_a  input  3  port A ULA opcode
- done_a  output  1  one-cycle pulse; resultado_a/erro_a valid
- resultado_a  output  32  last result delivered to A
- erro_a  output  1  divide-by-zero flag for last A result
- req_b, operando1_b, operando2_b, opcode_b, done_b, resultado_b, erro_b: identical set for port B
- ula_operando1  output  16  registered drive to ULA operando1
- ula_operando2  output  16  registered drive to ULA operando2
- ula_opcode  output  3  registered drive to ULA opcode
- ula_resultado  input  32  ULA resultado
- ocupado  output  1  high in any state other than OCIOSO

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state OCIOSO; counter 0; last-served pointer = B, so A wins the first tie.
  - All outputs 0: done_*, resultado_*, erro_*, ula_*, ocupado.
  - An operation in flight is dropped with no done. The requester still holds req and is re-served after reset.
- States: OCIOSO, ESPERA, CONCLUI.
- OCIOSO:
  - Samples req_a and req_b. Only one high: grant that port. Both high: grant the port not served last (round-robin). Neither: stay.
  - On grant with opcode 3'b010 and operando2 == 0: skip the ULA. Load resultado_x = 32'hFFFF_FFFF, erro_x = 1, go to CONCLUI.
  - On any other grant: load ula_operando1/2 and ula_opcode from the granted port, counter = LATENCIA, record the granted port, go to ESPERA.
  - The last-served pointer updates on every grant, including the divide-by-zero case.
- ESPERA:
  - Counter decrements each edge. The ula_* registers do not change.
  - At the edge where counter == 1: capture ula_resultado into resultado_x, erro_x = 0, go to CONCLUI.
  - req inputs are ignored while in ESPERA.
- CONCLUI:
  - done_x = 1 for exactly this one cycle; the other port's done stays 0.
  - Unconditional return to OCIOSO on the next edge.
  - req inputs are ignored here. This gives the requester the done edge to drop req without being re-served.
- Latency:
  - Request sampled in OCIOSO cycle k: done high in cycle k+LATENCIA+1.
  - Divide-by-zero: done high in cycle k+1.
- Throughput: one operation per LATENCIA+2 cycles. A req held high after done is treated as a new request.
- Register holding:
  - resultado_x and erro_x hold their value until the next completion for the same port.
  - ula_* outputs hold their last value when idle.
- Widths: the ULA result is taken as-is (32 bits); no truncation or sign handling in this block.
- Request changes: a req dropped while its operation is in ESPERA does not cancel it; done is still issued.

Test Plan:
- Single A request: A add 0x0003 + 0x0004, LATENCIA=2, req in cycle 0 -> ula_* loaded at edge 1, done_a high in cycle 3 only, resultado_a = 0x00000007, erro_a = 0, ocupado high in cycles 1-3.
- First tie after reset: req_a and req_b high together -> A served first (done_a), then B (done_b) LATENCIA+2 cycles later.
- Round-robin fairness: both requesters keep re-requesting -> grants alternate A,B,A,B over 4 operations; no port starved.
- Divide by zero: B opcode 010, operando2_b = 0 -> done_b in cycle k+1, resultado_b = 0xFFFFFFFF, erro_b = 1, ula_* unchanged. Then B 0x0010/0x0002 -> resultado_b = 0x00000008, erro_b = 0.
- Mid-operation reset: reset_n pulsed low during ESPERA -> all outputs 0 immediately, no done. After release, the held req_a is re-served and completes normally.
- Parameter sweep: LATENCIA=1 and LATENCIA=5 -> done at k+2 and k+6 respectively. ula_* stable across the whole ESPERA window (checked with a bench ULA model that corrupts the result if inputs change).

Source files
------------

// File: rtl/controle_ula.sv
// controle_ula: arbitrates two requesters onto one shared combinational ULA.
// Holds the ULA inputs for LATENCIA cycles, then returns the result by done pulse.
module controle_ula #(
  parameter int LATENCIA = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_a,
  input  logic [15:0] operando1_a,
  input  logic [15:0] operando2_a,
  input  logic [2:0]  opcode_a,
  output logic        done_a,
  output logic [31:0] resultado_a,
  output logic        erro_a,
  input  logic        req_b,
  input  logic [15:0] operando1_b,
  input  logic [15:0] operando2_b,
  input  logic [2:0]  opcode_b,
  output logic        done_b,
  output logic [31:0] resultado_b,
  output logic        erro_b,
  output logic [15:0] ula_operando1,
  output logic [15:0] ula_operando2,
  output logic [2:0]  ula_opcode,
  input  logic [31:0] ula_resultado,
  output logic        ocupado
);

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    CONCLUI
  } estado_t;

  localparam logic [3:0] LAT = 4'(LATENCIA);
  localparam logic [2:0] OP_DIV = 3'b010;

  estado_t     r_estado;
  logic [3:0]  r_cont;
  logic        r_ultimo_b;
  logic        r_porta_b;
  logic        r_done_a;
  logic        r_done_b;
  logic [31:0] r_res_a;
  logic [31:0] r_res_b;
  logic        r_err_a;
  logic        r_err_b;
  logic [15:0] r_ula_op1;
  logic [15:0] r_ula_op2;
  logic [2:0]  r_ula_opc;

  logic        w_grant;
  logic        w_sel_b;
  logic [15:0] w_op1;
  logic [15:0] w_op2;
  logic [2:0]  w_opc;
  logic        w_divz;

  // On a tie the port not served last wins; the operand mux follows the winner.
  always_comb begin
    w_grant = req_a | req_b;
    w_sel_b = req_b & (~req_a | ~r_ultimo_b);
    w_op1   = w_sel_b ? operando1_b : operando1_a;
    w_op2   = w_sel_b ? operando2_b : operando2_a;
    w_opc   = w_sel_b ? opcode_b    : opcode_a;
    w_divz  = (w_opc == OP_DIV) && (w_op2 == 16'h0000);
  end

  // Sequencer: grant, hold the ULA inputs through the settle window, deliver.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado   <= OCIOSO;
      r_cont     <= 4'd0;
      r_ultimo_b <= 1'b1;
      r_porta_b  <= 1'b0;
      r_done_a   <= 1'b0;
      r_done_b   <= 1'b0;
      r_res_a    <= 32'h0;
      r_res_b    <= 32'h0;
      r_err_a    <= 1'b0;
      r_err_b    <= 1'b0;
      r_ula_op1  <= 16'h0;
      r_ula_op2  <= 16'h0;
      r_ula_opc  <= 3'h0;
    end else begin
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      unique case (r_estado)
        OCIOSO: begin
          if (w_grant) begin
            r_ultimo_b <= w_sel_b;
            r_porta_b  <= w_sel_b;
            if (w_divz) begin
              r_estado <= CONCLUI;
              if (w_sel_b) begin
                r_res_b  <= 32'hFFFF_FFFF;
                r_err_b  <= 1'b1;
                r_done_b <= 1'b1;
              end else begin
                r_res_a  <= 32'hFFFF_FFFF;
                r_err_a  <= 1'b1;
                r_done_a <= 1'b1;
              end
            end else begin
              r_ula_op1 <= w_op1;
              r_ula_op2 <= w_op2;
              r_ula_opc <= w_opc;
              r_cont    <= LAT;
              r_estado  <= ESPERA;
            end
          end
        end
        ESPERA: begin
          r_cont <= r_cont - 4'd1;
          if (r_cont == 4'd1) begin
            r_estado <= CONCLUI;
            if (r_porta_b) begin
              r_res_b  <= ula_resultado;
              r_err_b  <= 1'b0;
              r_done_b <= 1'b1;
            end else begin
              r_res_a  <= ula_resultado;
              r_err_a  <= 1'b0;
              r_done_a <= 1'b1;
            end
          end
        end
        CONCLUI: begin
          r_estado <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  assign done_a        = r_done_a;
  assign done_b        = r_done_b;
  assign resultado_a   = r_res_a;
  assign resultado_b   = r_res_b;
  assign erro_a        = r_err_a;
  assign erro_b        = r_err_b;
  assign ula_operando1 = r_ula_op1;
  assign ula_operando2 = r_ula_op2;
  assign ula_opcode    = r_ula_opc;
  assign ocupado       = (r_estado != OCIOSO);

endmodule

// File: tb/tb_controle_ula.sv
// tb_controle_ula: three controllers (LATENCIA 2, 1, 5) against a
// transaction-level model plus a bench ULA that corrupts unstable inputs.
module tb_controle_ula;

  localparam int N = 3;

  logic        clock;
  logic        reset_n;
  logic        req_a [N];
  logic        req_b [N];
  logic [15:0] op1a  [N];
  logic [15:0] op2a  [N];
  logic [2:0]  opca  [N];
  logic [15:0] op1b  [N];
  logic [15:0] op2b  [N];
  logic [2:0]  opcb  [N];
  logic        done_a[N];
  logic        done_b[N];
  logic [31:0] res_a [N];
  logic [31:0] res_b [N];
  logic        err_a [N];
  logic        err_b [N];
  logic [15:0] u_op1 [N];
  logic [15:0] u_op2 [N];
  logic [2:0]  u_opc [N];
  logic [31:0] u_res [N];
  logic        ocup  [N];

  int          age   [N];
  logic [34:0] prev  [N];

  int n_vec;
  int n_err;

  // model state
  int          m_cyc;
  int          m_done  [N];
  bit          m_last_b[N];
  bit          m_pb    [N];
  logic [31:0] m_pres  [N];
  logic        e_done_a[N];
  logic        e_done_b[N];
  logic [31:0] e_res_a [N];
  logic [31:0] e_res_b [N];
  logic        e_err_a [N];
  logic        e_err_b [N];
  logic [15:0] e_u1    [N];
  logic [15:0] e_u2    [N];
  logic [2:0]  e_uc    [N];
  logic        e_ocup  [N];

  function automatic int lat(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
  endfunction

  function automatic logic [31:0] alu(input logic [15:0] a,
                                      input logic [15:0] b,
                                      input logic [2:0]  op);
    case (op)
      3'd0:    return 32'(a) + 32'(b);
      3'd1:    return 32'(a) - 32'(b);
      3'd2:    return (b == 16'h0) ? 32'hFFFF_FFFF : 32'(a / b);
      3'd3:    return 32'(a) * 32'(b);
      3'd4:    return {16'h0, a & b};
      3'd5:    return {16'h0, a | b};
      3'd6:    return {16'h0, a ^ b};
      default: return {a, b};
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    controle_ula #(.LATENCIA(L)) u_dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_a        (req_a[g]),
      .operando1_a  (op1a[g]),
      .operando2_a  (op2a[g]),
      .opcode_a     (opca[g]),
      .done_a       (done_a[g]),
      .resultado_a  (res_a[g]),
      .erro_a       (err_a[g]),
      .req_b        (req_b[g]),
      .operando1_b  (op1b[g]),
      .operando2_b  (op2b[g]),
      .opcode_b     (opcb[g]),
      .done_b       (done_b[g]),
      .resultado_b  (res_b[g]),
      .erro_b       (err_b[g]),
      .ula_operando1(u_op1[g]),
      .ula_operando2(u_op2[g]),
      .ula_opcode   (u_opc[g]),
      .ula_resultado(u_res[g]),
      .ocupado      (ocup[g])
    );
    assign u_res[g] = (age[g] >= L - 1)
                    ? alu(u_op1[g], u_op2[g], u_opc[g])
                    : alu(u_op1[g], u_op2[g], u_opc[g]) ^ 32'h5A5A_5A5A;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // bench ULA: cycles the inputs have been stable
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if ({u_op1[i], u_op2[i], u_opc[i]} !== prev[i]) age[i] <= 0;
      else if (age[i] < 1000) age[i] <= age[i] + 1;
      prev[i] <= {u_op1[i], u_op2[i], u_opc[i]};
    end
  end

  task automatic model_reset();
    m_cyc = 0;
    for (int i = 0; i < N; i++) begin
      m_done[i] = -1;
      m_last_b[i] = 1'b1;
      m_pb[i] = 1'b0;
      m_pres[i] = 32'h0;
      e_done_a[i] = 1'b0;
      e_done_b[i] = 1'b0;
      e_res_a[i] = 32'h0;
      e_res_b[i] = 32'h0;
      e_err_a[i] = 1'b0;
      e_err_b[i] = 1'b0;
      e_u1[i] = 16'h0;
      e_u2[i] = 16'h0;
      e_uc[i] = 3'h0;
      e_ocup[i] = 1'b0;
    end
  endtask

  // one clock edge of the transaction model: cycle m_cyc ends here
  task automatic model_step();
    int dn;
    bit sb;
    bit dz;
    logic [15:0] o1;
    logic [15:0] o2;
    logic [2:0]  oc;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      dn = m_done[i];
      e_done_a[i] = 1'b0;
      e_done_b[i] = 1'b0;
      if (m_cyc + 1 == m_done[i]) begin
        if (m_pb[i]) begin
          e_done_b[i] = 1'b1; e_res_b[i] = m_pres[i]; e_err_b[i] = 1'b0;
        end else begin
          e_done_a[i] = 1'b1; e_res_a[i] = m_pres[i]; e_err_a[i] = 1'b0;
        end
      end
      if (m_cyc > m_done[i] && (req_a[i] || req_b[i])) begin
        sb = (req_a[i] && req_b[i]) ? !m_last_b[i] : bit'(req_b[i]);
        o1 = sb ? op1b[i] : op1a[i];
        o2 = sb ? op2b[i] : op2a[i];
        oc = sb ? opcb[i] : opca[i];
        dz = (oc == 3'b010) && (o2 == 16'h0);
        m_last_b[i] = sb;
        m_pb[i] = sb;
        if (dz) begin
          dn = m_cyc + 1;
          if (sb) begin
            e_done_b[i] = 1'b1; e_res_b[i] = 32'hFFFF_FFFF; e_err_b[i] = 1'b1;
          end else begin
            e_done_a[i] = 1'b1; e_res_a[i] = 32'hFFFF_FFFF; e_err_a[i] = 1'b1;
          end
        end else begin
          dn = m_cyc + lat(i) + 1;
          m_pres[i] = alu(o1, o2, oc);
          e_u1[i] = o1;
          e_u2[i] = o2;
          e_uc[i] = oc;
        end
        m_done[i] = dn;
      end
      e_ocup[i] = (m_cyc + 1 <= dn);
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic cmp(input string nm, input int i,
                     input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d got %h want %h", nm, i, got, exp);
    end
  endtask

  task automatic chk_all();
    for (int i = 0; i < N; i++) begin
      cmp("done_a", i, 32'(done_a[i]), 32'(e_done_a[i]));
      cmp("done_b", i, 32'(done_b[i]), 32'(e_done_b[i]));
      cmp("resultado_a", i, res_a[i], e_res_a[i]);
      cmp("resultado_b", i, res_b[i], e_res_b[i]);
      cmp("erro_a", i, 32'(err_a[i]), 32'(e_err_a[i]));
      cmp("erro_b", i, 32'(err_b[i]), 32'(e_err_b[i]));
      cmp("ula_operando1", i, 32'(u_op1[i]), 32'(e_u1[i]));
      cmp("ula_operando2", i, 32'(u_op2[i]), 32'(e_u2[i]));
      cmp("ula_opcode", i, 32'(u_opc[i]), 32'(e_uc[i]));
      cmp("ocupado", i, 32'(ocup[i]), 32'(e_ocup[i]));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk_all();
  endtask

  task automatic wait_done(input int i, input bit b, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = b ? bit'(done_b[i]) : bit'(done_a[i]);
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done inst%0d got no done want done", i);
    end
  endtask

  task automatic wait_any(input int i, output bit pb, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    pb = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = done_a[i] | done_b[i];
      pb = done_b[i];
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_any inst%0d got no done want done", i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit pb;
    bit order[4];
    int gap[4];
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_a[i] = 1'b0; req_b[i] = 1'b0;
      op1a[i] = '0; op2a[i] = '0; opca[i] = '0;
      op1b[i] = '0; op2b[i] = '0; opcb[i] = '0;
    end
    model_reset();
    tick();
    tick();
    cmp("rst_ocupado", 0, 32'(ocup[0]), 32'd0);
    cmp("rst_resultado_a", 0, res_a[0], 32'd0);
    reset_n = 1'b1;

    // single A add 3 + 4
    op1a[0] = 16'h0003; op2a[0] = 16'h0004; opca[0] = 3'd0; req_a[0] = 1'b1;
    tick();
    cmp("t1_ula_op1", 0, 32'(u_op1[0]), 32'h3);
    cmp("t1_ocupado_c1", 0, 32'(ocup[0]), 32'd1);
    tick();
    cmp("t1_done_c2", 0, 32'(done_a[0]), 32'd0);
    tick();
    cmp("t1_done_c3", 0, 32'(done_a[0]), 32'd1);
    cmp("t1_resultado", 0, res_a[0], 32'h0000_0007);
    req_a[0] = 1'b0;
    tick();
    cmp("t1_ocupado_c4", 0, 32'(ocup[0]), 32'd0);

    // first tie after reset goes to A, then B
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
    op1a[0] = 16'h0005; op2a[0] = 16'h0006; opca[0] = 3'd3; req_a[0] = 1'b1;
    op1b[0] = 16'h0009; op2b[0] = 16'h0002; opcb[0] = 3'd1; req_b[0] = 1'b1;
    wait_done(0, 1'b0, n);
    cmp("t2_lat_a", 0, 32'(n), 32'd3);
    cmp("t2_resultado_a", 0, res_a[0], 32'd30);
    req_a[0] = 1'b0;
    wait_done(0, 1'b1, n);
    cmp("t2_gap_b", 0, 32'(n), 32'd4);
    cmp("t2_resultado_b", 0, res_b[0], 32'd7);
    req_b[0] = 1'b0;
    tick();

    // round robin with both held
    op1a[0] = 16'h0010; op2a[0] = 16'h00FF; opca[0] = 3'd4; req_a[0] = 1'b1;
    op1b[0] = 16'h00F0; op2b[0] = 16'h000F; opcb[0] = 3'd5; req_b[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_any(0, pb, n);
      order[j] = pb;
      gap[j] = n;
    end
    req_a[0] = 1'b0;
    req_b[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cmp("t3_order", j, 32'(order[j]), 32'(j % 2));
      if (j > 0) cmp("t3_gap", j, 32'(gap[j]), 32'd4);
    end
    cmp("t3_resultado_a", 0, res_a[0], 32'h10);
    cmp("t3_resultado_b", 0, res_b[0], 32'hFF);
    tick();

    // divide by zero on B skips the ULA
    op1b[0] = 16'h1234; op2b[0] = 16'h0000; opcb[0] = 3'd2; req_b[0] = 1'b1;
    tick();
    cmp("t4_done_b", 0, 32'(done_b[0]), 32'd1);
    cmp("t4_resultado_b", 0, res_b[0], 32'hFFFF_FFFF);
    cmp("t4_erro_b", 0, 32'(err_b[0]), 32'd1);
    cmp("t4_ula_hold", 0, 32'(u_op1[0]), 32'h00F0);
    req_b[0] = 1'b0;
    tick();
    op1b[0] = 16'h0010; op2b[0] = 16'h0002;
    req_b[0] = 1'b1;
    wait_done(0, 1'b1, n);
    cmp("t4_div_lat", 0, 32'(n), 32'd3);
    cmp("t4_div_res", 0, res_b[0], 32'h8);
    cmp("t4_div_erro", 0, 32'(err_b[0]), 32'd0);
    req_b[0] = 1'b0;
    tick();

    // reset during ESPERA drops the operation; held req is re-served
    op1a[0] = 16'h0007; op2a[0] = 16'h0008; opca[0] = 3'd0; req_a[0] = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    cmp("t5_ocupado", 0, 32'(ocup[0]), 32'd0);
    cmp("t5_ula_op1", 0, 32'(u_op1[0]), 32'd0);
    cmp("t5_resultado_a", 0, res_a[0], 32'd0);
    cmp("t5_resultado_b", 0, res_b[0], 32'd0);
    tick();
    reset_n = 1'b1;
    wait_done(0, 1'b0, n);
    cmp("t5_lat", 0, 32'(n), 32'd3);
    cmp("t5_resultado", 0, res_a[0], 32'd15);
    req_a[0] = 1'b0;
    tick();

    // LATENCIA 1 and 5
    op1a[1] = 16'h0100; op2a[1] = 16'h0003; opca[1] = 3'd6; req_a[1] = 1'b1;
    wait_done(1, 1'b0, n);
    cmp("t6_lat1", 1, 32'(n), 32'd2);
    cmp("t6_res1", 1, res_a[1], 32'h0000_0103);
    req_a[1] = 1'b0;
    tick();
    op1b[2] = 16'h00FF; op2b[2] = 16'h0101; opcb[2] = 3'd3; req_b[2] = 1'b1;
    wait_done(2, 1'b1, n);
    cmp("t6_lat5", 2, 32'(n), 32'd6);
    cmp("t6_res5", 2, res_b[2], 32'h0000_FFFF);
    req_b[2] = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
